// File: rtl/mem_scan_pkg.sv
// rtl/mem_scan_pkg.sv - shared types and checksum fold for the memory scan engine
package mem_scan_pkg;

   localparam int CHECKSUM_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OP_CHECK = 1'b0,
      OP_FILL  = 1'b1
   } op_t;

   // Rotate-left-by-one then xor in the zero-extended word.
   function automatic logic [CHECKSUM_W-1:0] checksum_step(
      input logic [CHECKSUM_W-1:0] acc,
      input logic [CHECKSUM_W-1:0] word
   );
      return {acc[CHECKSUM_W-2:0], acc[CHECKSUM_W-1]} ^ word;
   endfunction

endpackage

// File: rtl/mem_scan_engine.sv
// rtl/mem_scan_engine.sv - sequential CHECK/FILL sweep driver for a write-every-cycle block RAM
module mem_scan_engine
   import mem_scan_pkg::*;
#(
   parameter int WID_MEM      = 5,
   parameter int DEPTH_MEM    = 2048,
   parameter int SCRATCH_ADDR = DEPTH_MEM - 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               op,
   input  logic [WID_MEM-1:0] seed,
   input  logic [31:0]        expected_sum,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [31:0]        checksum,
   output logic [31:0]        mem_raddr,
   output logic [31:0]        mem_waddr,
   output logic [WID_MEM-1:0] mem_din,
   input  logic [WID_MEM-1:0] mem_dout
);

   localparam int              AW   = $clog2(DEPTH_MEM);
   localparam int              N    = DEPTH_MEM - 1;
   localparam logic [AW-1:0]   LAST = AW'(N - 1);
   localparam logic [31:0]     SCR  = 32'(SCRATCH_ADDR);

   state_t                  state_q, state_d;
   op_t                     op_q, op_d;
   logic [WID_MEM-1:0]      seed_q, seed_d;
   logic [31:0]             exp_q, exp_d;
   logic [AW-1:0]           a_q, a_d, a_nxt;
   logic [CHECKSUM_W-1:0]   acc_q, acc_d;
   logic                    wb_q, wb_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    pass_q, pass_d;
   logic [31:0]             checksum_q, checksum_d;
   logic [31:0]             raddr_q, raddr_d;
   logic [31:0]             waddr_q, waddr_d;
   logic [WID_MEM-1:0]      din_q, din_d;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      seed_d     = seed_q;
      exp_d      = exp_q;
      a_d        = a_q;
      acc_d      = acc_q;
      wb_d       = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      checksum_d = checksum_q;
      raddr_d    = SCR;
      waddr_d    = SCR;
      din_d      = '0;
      a_nxt      = a_q + AW'(1);

      // wb_q marks cycles where mem_dout holds the word read one cycle earlier
      if (wb_q) begin
         acc_d = checksum_step(acc_q, CHECKSUM_W'(mem_dout));
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = op_t'(op);
               seed_d  = seed;
               exp_d   = expected_sum;
               a_d     = '0;
               acc_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
               if (op_t'(op) == OP_FILL) begin
                  waddr_d = '0;
                  din_d   = seed;
               end else begin
                  raddr_d = '0;
               end
            end
         end
         RUN: begin
            if (a_q != LAST) begin
               a_d = a_nxt;
               if (op_q == OP_FILL) begin
                  waddr_d = 32'(a_nxt);
                  din_d   = WID_MEM'(a_nxt) ^ seed_q;
               end else begin
                  raddr_d = 32'(a_nxt);
                  waddr_d = 32'(a_q);
                  wb_d    = 1'b1;
               end
            end else if (op_q == OP_FILL) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = 1'b1;
            end else begin
               state_d = DRAIN;
               waddr_d = 32'(a_q);
               wb_d    = 1'b1;
            end
         end
         DRAIN: begin
            state_d    = DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            checksum_d = acc_d;
            pass_d     = (acc_d == exp_q);
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         op_q       <= OP_CHECK;
         seed_q     <= '0;
         exp_q      <= '0;
         a_q        <= '0;
         acc_q      <= '0;
         wb_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         checksum_q <= '0;
         raddr_q    <= SCR;
         waddr_q    <= SCR;
         din_q      <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         seed_q     <= seed_d;
         exp_q      <= exp_d;
         a_q        <= a_d;
         acc_q      <= acc_d;
         wb_q       <= wb_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         checksum_q <= checksum_d;
         raddr_q    <= raddr_d;
         waddr_q    <= waddr_d;
         din_q      <= din_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign checksum  = checksum_q;
   assign mem_raddr = raddr_q;
   assign mem_waddr = waddr_q;
   // Write-back data is the memory's own registered dout, steered by a registered select.
   assign mem_din   = wb_q ? mem_dout : din_q;

endmodule

// File: doc/mem_scan_engine.md
Name: mem_scan_engine

Overview:
- Driver stage that sits directly upstream of the block-RAM memory wrapper (clk, raddr, waddr, din, dout, reset). It owns that memory's raddr/waddr/din and consumes its dout.
- On command it does one of two sequential sweeps:
  - CHECK: reads every data word, folds it into a checksum, compares against an expected value, and writes each word back unchanged.
  - FILL: writes a seeded pattern into every data word.
- The memory writes on every clock and has no write enable. This engine therefore reserves one scratch word, SCRATCH_ADDR, as the parking target for all non-functional writes.

Parameters:
- WID_MEM, 5, memory word width (1..32).
- DEPTH_MEM, 2048, memory depth. Data words are addresses 0..DEPTH_MEM-2.
- SCRATCH_ADDR, DEPTH_MEM-1, reserved parking word. Never scanned; its contents are undefined.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle command strobe; ignored while busy=1
- op  in  1  sampled with start: 0 = CHECK, 1 = FILL
- seed  in  WID_MEM  FILL pattern seed, sampled with start
- expected_sum  in  32  CHECK reference, sampled with start
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at end of sweep
- pass  out  1  result, held until the next start
- checksum  out  32  CHECK result, held until the next start
- mem_raddr  out  32  to memory raddr
- mem_waddr  out  32  to memory waddr
- mem_din  out  WID_MEM  to memory din
- mem_dout  in  WID_MEM  from memory dout; registered, 1-cycle read latency, read-first

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, pass=0, checksum=0, mem_raddr=SCRATCH_ADDR, mem_waddr=SCRATCH_ADDR, mem_din=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: park all memory outputs (raddr=waddr=SCRATCH_ADDR, din=0).
  - When start=1 is sampled, latch op, seed and expected_sum, clear the accumulator, set busy=1, go to RUN.
- RUN: address counter a runs 0..N-1, where N=DEPTH_MEM-1, one address per cycle.
  - CHECK: mem_raddr=a. In the following cycle, mem_waddr=a-1 and mem_din=mem_dout, a lossless write-back.
    - Read and write addresses therefore never coincide.
    - The accumulator updates in every cycle where mem_dout is valid.
  - FILL: mem_waddr=a, mem_din=a[WID_MEM-1:0]^seed, mem_raddr=SCRATCH_ADDR.
  - After a=N-1: CHECK goes to DRAIN; FILL goes to DONE.
- DRAIN (CHECK only, 1 cycle): capture the last word, write back address N-1, park raddr.
- DONE (1 cycle): done=1, busy=0, memory outputs parked.
  - checksum and pass are updated in this cycle.
  - CHECK: pass=(acc==expected_sum). FILL: pass=1, checksum unchanged from its previous value.
  - Go to IDLE. A start in this cycle is ignored.
- Checksum update: acc = {acc[30:0],acc[31]} ^ zero_extend(word). Start value is 0. Folding order is ascending address.
- Latency: busy is high for N+1 cycles (CHECK) or N cycles (FILL), starting the cycle after start. done follows immediately.
- Address counter width is $clog2(DEPTH_MEM); it is zero-extended to 32 bits on the memory ports. The counter never wraps, because the terminal compare is at N-1.
- Reset mid-sweep: return to IDLE and apply reset values on the next edge.
  - Words already written in FILL keep their new value.
  - CHECK write-backs already issued are value-preserving, so memory is never corrupted except at SCRATCH_ADDR.
- start while busy: ignored, with no queueing.

Decomposition:
- Package mem_scan_pkg contains:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - op enum (OP_CHECK=0, OP_FILL=1)
  - CHECKSUM_W=32
  - function checksum_step(acc, word)
- No sub-module. Single FSM plus counter and accumulator.
- The bench instantiates mem_scan_engine wired to the memory wrapper.

Test Plan (WID_MEM=5, DEPTH_MEM=8, N=7, memory init ram[i]=i):
- CHECK, expected_sum=0x4:
  - mem_raddr steps 0..6 on consecutive cycles; mem_waddr lags by one cycle.
  - busy high 8 cycles; done pulses next; checksum=0x00000004, pass=1.
  - ram[0..6] unchanged.
- CHECK, expected_sum=0x5 → checksum=0x4, pass=0.
- FILL, seed=0x1F:
  - waddr 0..6 over 7 busy cycles; afterwards ram[0]=0x1F, ram[6]=0x19; pass=1.
  - Follow with CHECK, expected_sum=0x571 → checksum=0x00000571, pass=1.
- start pulsed again 3 cycles into CHECK → ignored; exactly one done; result identical to the first scenario.
- reset asserted at FILL a=3:
  - Next cycle all outputs at reset values.
  - ram[0..2] hold the pattern (ram[3] too, if its write edge preceded reset); ram[4..6] unchanged.
  - A subsequent CHECK completes normally.
- IDLE for 20 cycles after reset: mem_waddr=7, mem_din=0 throughout; ram[0..6] unchanged.
